// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and helpers for the pipeline stall/flush sequencer.
//   pctrl_state_t  - sequencer state (RUN, MEM_WAIT, MDU_BUSY)
//   DEF_*          - default parameter values used by pipeline_ctrl
//   cnt_width()    - bits needed for a down/up counter that must hold 0..max_val
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } pctrl_state_t;

  localparam int DEF_MDU_LAT = 8;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_CNT_W   = 32;

  // One spare bit above $clog2 so a counter can hold max_val itself, and so
  // a value of 1 still gets a 1-bit counter.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk    - clock, rising edge
//   rst_n  - async active-low clear
//   inc    - count this cycle
//   count  - current value [W-1:0]
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Hold at the top value so long runs read as "at least this many" rather than
  // wrapping to a misleadingly small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use stalls and E-stage redirects with data-memory waits and the
// iterative MDU, drives stage enables and bubble inserts, and counts stalls/flushes.
//   clk, rst_n                 - clock / async active-low reset
//   stall_lu                   - load-use hazard (load in E, dependent in D)
//   flush_branch, jump_e       - redirect resolved in E
//   dmem_req_m, dmem_ready     - M-stage memory access and its completion
//   mdu_op_e                   - E-stage instruction is MUL/DIV/REM
//   en_f..en_w                 - PC and pipeline register load enables
//   flush_d..flush_w           - bubble inserts into F-D, D-E, E-M, M-W
//   mdu_start, mdu_busy        - MDU launch pulse / MDU in progress
//   mem_timeout                - sticky: a memory wait reached TIMEOUT cycles
//   stall_cnt, flush_cnt       - saturating performance counters
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_LAT = DEF_MDU_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_lu,
  input  logic             flush_branch,
  input  logic             jump_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ready,
  input  logic             mdu_op_e,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_m,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int MCW = cnt_width(MDU_LAT);
  localparam int WCW = cnt_width(TIMEOUT);
  localparam logic [MCW-1:0] MDU_RELOAD = MCW'(MDU_LAT - 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(TIMEOUT);

  pctrl_state_t   state;
  logic [MCW-1:0] mdu_cnt;
  logic [WCW-1:0] wait_cnt;
  logic           mem_stall;
  logic           advance;
  logic           redirect_taken;

  assign mem_stall = dmem_req_m & ~dmem_ready;
  assign mdu_busy  = (state == MDU_BUSY);

  // Decode stage controls. "advance" marks cycles where E moves forward; only
  // then do redirects and load-use stalls matter, since a frozen E can neither
  // resolve a branch nor hand a load result to D. Reset overrides everything so
  // the pipeline registers hold bubbles while rst_n is low.
  always_comb begin
    en_f           = 1'b1;
    en_d           = 1'b1;
    en_e           = 1'b1;
    en_m           = 1'b1;
    en_w           = 1'b1;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_m        = 1'b0;
    flush_w        = 1'b0;
    mdu_start      = 1'b0;
    advance        = 1'b0;
    redirect_taken = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_stall) begin
          // Older instruction in M wins over a new MDU op in E.
          {en_f, en_d, en_e, en_m} = 4'b0000;
          flush_w = 1'b1;
        end else if (mdu_op_e) begin
          mdu_start = 1'b1;
          {en_f, en_d, en_e} = 3'b000;
          flush_m = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          {en_f, en_d, en_e, en_m} = 4'b0000;
          flush_w = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      MDU_BUSY: begin
        if (mdu_cnt != '0) begin
          {en_f, en_d, en_e} = 3'b000;
          flush_m = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin
        advance = 1'b1;
      end
    endcase

    // A redirect kills the wrong-path instructions in D and E, which makes any
    // load-use stall on them moot.
    if (advance && (flush_branch || jump_e)) begin
      flush_d        = 1'b1;
      flush_e        = 1'b1;
      redirect_taken = 1'b1;
    end else if (advance && stall_lu) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      flush_e = 1'b1;
    end

    if (!rst_n) begin
      {en_f, en_d, en_e, en_m, en_w}     = 5'b00000;
      {flush_d, flush_e, flush_m, flush_w} = 4'b1111;
      mdu_start      = 1'b0;
      redirect_taken = 1'b0;
    end
  end

  // Sequencer state. wait_cnt counts MEM_WAIT cycles starting at 1 and parks at
  // the limit; reaching the limit latches mem_timeout but never aborts the wait.
  // mdu_cnt counts down the remaining stall cycles; E advances when it hits 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      mdu_cnt     <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end else if (mdu_op_e) begin
            state   <= MDU_BUSY;
            mdu_cnt <= MDU_RELOAD;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt == WAIT_LIMIT) begin
            mem_timeout <= 1'b1;
          end
          if (mem_stall) begin
            if (wait_cnt != WAIT_LIMIT) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        MDU_BUSY: begin
          if (mdu_cnt == '0) begin
            state <= RUN;
          end else begin
            mdu_cnt <= mdu_cnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // The MDU owns E for its whole run, so nothing older may still be in M
  // issuing a memory access.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == MDU_BUSY) |-> !dmem_req_m);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~en_f),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_taken),
    .count (flush_cnt)
  );

endmodule
